// File: rtl/mux_pkt_arbiter.sv
// Packet-level round-robin arbiter driving the one-hot select of a 2:1 flit mux.
// Optional stall-timeout release is enabled by defining MUX_ARB_TIMEOUT_EN.

module mux_pkt_arbiter #(
    parameter int               TYPEW     = 2,
    parameter logic [TYPEW-1:0] TYPE_NONE = 2'b00,
    parameter logic [TYPEW-1:0] TYPE_HEAD = 2'b01,
    parameter logic [TYPEW-1:0] TYPE_TAIL = 2'b10,
    parameter logic [TYPEW-1:0] TYPE_DATA = 2'b11,
    parameter int               TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             ivalid_0,
    input  logic [TYPEW-1:0] itype_0,
    input  logic             ivalid_1,
    input  logic [TYPEW-1:0] itype_1,
    input  logic             iready,
    output logic [1:0]       sel,
    output logic             grant_0,
    output logic             grant_1,
    output logic             busy,
    output logic             err_flit,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    // Without the feature the stall counter is held at zero and is optimised away.
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic       err_flit_q, err_flit_d;
    logic       timeout_q, timeout_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;

    logic             req_0, req_1;
    logic             stray_0, stray_1;
    logic             own_port;
    logic             own_valid;
    logic [TYPEW-1:0] own_type;
    logic             own_grant;

    function automatic logic is_non_head(input logic [TYPEW-1:0] t);
        return (t == TYPE_NONE) || (t == TYPE_DATA) || (t == TYPE_TAIL);
    endfunction

    assign req_0   = ivalid_0 && (itype_0 == TYPE_HEAD);
    assign req_1   = ivalid_1 && (itype_1 == TYPE_HEAD);
    assign stray_0 = ivalid_0 && is_non_head(itype_0);
    assign stray_1 = ivalid_1 && is_non_head(itype_1);

    assign grant_0 = sel_q[0] & ivalid_0 & iready;
    assign grant_1 = sel_q[1] & ivalid_1 & iready;

    // Signals of whichever input currently owns the lock.
    assign own_port  = (state_q == LOCK1);
    assign own_valid = own_port ? ivalid_1 : ivalid_0;
    assign own_type  = own_port ? itype_1 : itype_0;
    assign own_grant = grant_0 | grant_1;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        err_flit_d  = 1'b0;
        timeout_d   = 1'b0;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            IDLE: begin
                err_flit_d  = stray_0 | stray_1;
                stall_cnt_d = 8'd0;
                if (req_0 && req_1) begin
                    state_d = rr_ptr_q ? LOCK1 : LOCK0;
                end else if (req_0) begin
                    state_d = LOCK0;
                end else if (req_1) begin
                    state_d = LOCK1;
                end
            end
            LOCK0, LOCK1: begin
                if (own_grant) begin
                    stall_cnt_d = 8'd0;
                    if (own_type == TYPE_TAIL) begin
                        state_d  = IDLE;
                        rr_ptr_d = ~own_port;
                    end
                end else if (!own_valid && TIMEOUT_EN) begin
                    // Backpressure stalls (valid but not ready) deliberately do not count.
                    if (stall_cnt_q == STALL_LIMIT - 8'd1) begin
                        state_d     = IDLE;
                        rr_ptr_d    = ~own_port;
                        timeout_d   = 1'b1;
                        stall_cnt_d = 8'd0;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sel_d  = (state_d == LOCK0) ? 2'b01 :
                 (state_d == LOCK1) ? 2'b10 : 2'b00;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= IDLE;
            sel_q       <= 2'b00;
            busy_q      <= 1'b0;
            rr_ptr_q    <= 1'b0;
            err_flit_q  <= 1'b0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            rr_ptr_q    <= rr_ptr_d;
            err_flit_q  <= err_flit_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign sel      = sel_q;
    assign busy     = busy_q;
    assign err_flit = err_flit_q;
    assign timeout  = timeout_q;

endmodule
